// File: rtl/rv_mdu_if.sv
// Request/response bundle between the control FSM and the multiply/divide unit.
// Master drives start/op/src_a/src_b/flush; slave returns busy/done/result.
// Timing: the bundle is unregistered; all timing is set by the unit behind it.
interface rv_mdu_if #(
  parameter int unsigned DPWIDTH = 32
);
  logic               start;
  logic [2:0]         op;
  logic [DPWIDTH-1:0] src_a;
  logic [DPWIDTH-1:0] src_b;
  logic               flush;
  logic               busy;
  logic               done;
  logic [DPWIDTH-1:0] result;

  modport master (output start, op, src_a, src_b, flush,
                  input  busy, done, result);
  modport slave  (input  start, op, src_a, src_b, flush,
                  output busy, done, result);
endinterface

// File: rtl/rv_mdu.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply, restoring divide.
// Latency: done in cycle DPWIDTH+2 after start (cycle 1 for fast special divides).
// Backpressure: start is ignored while busy; flush aborts CALC/FIX with no done.
// Ports: clk_i, rst_ni (async active-low), mdu (slave side of rv_mdu_if).
module rv_mdu #(
  parameter int unsigned DPWIDTH      = 32,
  parameter bit          SPECIAL_FAST = 1'b1
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  rv_mdu_if.slave mdu
);
  localparam int unsigned W  = DPWIDTH;
  localparam int unsigned CW = $clog2(DPWIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [W-1:0]     mcand_q, mcand_d;      // multiplicand or divisor magnitude
  logic [2*W-1:0]   acc_q, acc_d;          // product {hi,lo} or {remainder,quotient}
  logic             neg_q, neg_d;          // product/quotient sign
  logic             rneg_q, rneg_d;        // remainder sign
  logic             spec_q, spec_d;        // divide-by-zero or signed overflow
  logic [W-1:0]     spec_res_q, spec_res_d;
  logic [W-1:0]     result_q, result_d;

  // Operand decode at issue time
  logic         a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;
  logic         div_zero, div_ovf, in_spec;
  logic [W-1:0] in_spec_res;

  assign a_signed = (mdu.op == 3'd1) || (mdu.op == 3'd2) || (mdu.op == 3'd4) || (mdu.op == 3'd6);
  assign b_signed = (mdu.op == 3'd1) || (mdu.op == 3'd4) || (mdu.op == 3'd6);
  assign a_neg    = a_signed && mdu.src_a[W-1];
  assign b_neg    = b_signed && mdu.src_b[W-1];
  // The most-negative value maps to itself, which is the correct unsigned magnitude.
  assign a_mag    = a_neg ? -mdu.src_a : mdu.src_a;
  assign b_mag    = b_neg ? -mdu.src_b : mdu.src_b;

  assign div_zero = mdu.op[2] && (mdu.src_b == '0);
  assign div_ovf  = ((mdu.op == 3'd4) || (mdu.op == 3'd6)) &&
                    (mdu.src_a == {1'b1, {(W-1){1'b0}}}) && (&mdu.src_b);
  assign in_spec  = div_zero || div_ovf;

  always_comb begin
    in_spec_res = '0;
    if (div_zero)     in_spec_res = mdu.op[1] ? mdu.src_a : '1;
    else if (div_ovf) in_spec_res = mdu.op[1] ? '0 : mdu.src_a;
  end

  // One iteration of each algorithm
  logic [W:0] mul_sum, rem_sh, rem_diff;
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
  assign rem_diff = rem_sh - {1'b0, mcand_q};

  // Sign correction and half select
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, fix_res;
  assign prod_fix = neg_q  ? -acc_q          : acc_q;
  assign quo_fix  = neg_q  ? -acc_q[W-1:0]   : acc_q[W-1:0];
  assign rem_fix  = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_comb begin
    fix_res = '0;
    case (op_q)
      3'd0:                fix_res = prod_fix[W-1:0];
      3'd1, 3'd2, 3'd3:    fix_res = prod_fix[2*W-1:W];
      3'd4, 3'd5:          fix_res = quo_fix;
      default:             fix_res = rem_fix;
    endcase
    if (spec_q) fix_res = spec_res_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    result_d   = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (mdu.start) begin
          op_d       = mdu.op;
          cnt_d      = '0;
          neg_d      = a_neg ^ b_neg;
          rneg_d     = a_neg;
          spec_d     = in_spec;
          spec_res_d = in_spec_res;
          mcand_d    = mdu.op[2] ? b_mag : a_mag;
          acc_d      = {{W{1'b0}}, (mdu.op[2] ? a_mag : b_mag)};
          if (in_spec && SPECIAL_FAST) begin
            state_d  = S_DONE;
            result_d = in_spec_res;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (mdu.flush) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[2]) begin
            // Restore (keep shifted remainder) when the trial subtract goes negative
            acc_d = rem_diff[W] ? {rem_sh[W-1:0],   acc_q[W-2:0], 1'b0}
                                : {rem_diff[W-1:0], acc_q[W-2:0], 1'b1};
          end else begin
            acc_d = {mul_sum, acc_q[W-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W-1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (mdu.flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_res;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      result_q   <= result_d;
    end
  end

  assign mdu.busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign mdu.done   = (state_q == S_DONE);
  assign mdu.result = result_q;
endmodule
